// File: rtl/flag_file_pkg.sv
// flag_file_pkg
// Shared definitions for the multi-context condition-flag file:
//   - cond_e        : 3-bit branch condition codes (the cond_code.h set,
//                     extended with NOT_EQUAL, LESS_OR_EQUAL, OVERFLOW, CARRY)
//   - FLAG_*        : bit positions of c/z/v/n inside a 4-bit flag vector
//   - COND_HI/LO    : location of the condition field in a branch instruction
//   - ctxWidth()    : context index width, never narrower than one bit
package flag_file_pkg;

  typedef enum logic [2:0] {
    COND_EQUAL            = 3'd0,
    COND_NOT_EQUAL        = 3'd1,
    COND_GREATER          = 3'd2,
    COND_LESS             = 3'd3,
    COND_GREATER_OR_EQUAL = 3'd4,
    COND_LESS_OR_EQUAL    = 3'd5,
    COND_OVERFLOW         = 3'd6,
    COND_CARRY            = 3'd7
  } cond_e;

  // Flag vector layout is {c, z, v, n}, MSB first
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  localparam int COND_HI = 10;
  localparam int COND_LO = 8;

  // A single context still needs a one-bit index so ports never collapse
  function automatic int ctxWidth(input int numCtx);
    return (numCtx > 1) ? $clog2(numCtx) : 1;
  endfunction

endpackage

// File: rtl/flag_file_if.sv
// flag_file_if
// Bundles the issue, ALU-writeback and branch-evaluation signals of the
// flag file.
//   master : decode/issue + ALU side (drives requests, reads results)
//   slave  : the flag file itself
// Parameter CTX_W must match the context width of the attached flag_file.
interface flag_file_if #(parameter int CTX_W = 2) ();

  logic             issue_valid;
  logic [CTX_W-1:0] issue_ctx;
  logic             issue_ready;

  logic             alu_valid;
  logic [CTX_W-1:0] alu_ctx;
  logic             alu_z;
  logic             alu_v;
  logic             alu_n;
  logic             alu_c;

  logic             br_valid;
  logic [CTX_W-1:0] br_ctx;
  logic [15:0]      br_instr;
  logic             br_stall;
  logic             br_resp_valid;
  logic             br_taken;

  logic             flag_err;

  modport master (
    output issue_valid, issue_ctx,
    output alu_valid, alu_ctx, alu_z, alu_v, alu_n, alu_c,
    output br_valid, br_ctx, br_instr,
    input  issue_ready, br_stall, br_resp_valid, br_taken, flag_err
  );

  modport slave (
    input  issue_valid, issue_ctx,
    input  alu_valid, alu_ctx, alu_z, alu_v, alu_n, alu_c,
    input  br_valid, br_ctx, br_instr,
    output issue_ready, br_stall, br_resp_valid, br_taken, flag_err
  );

endinterface

// File: rtl/flag_file_cond_eval.sv
// cond_eval
// Purely combinational branch-condition evaluator.
//   flags_i : {c, z, v, n} flag vector
//   cond_i  : 3-bit condition code
//   taken_o : 1 when the condition holds for the given flags
module cond_eval
  import flag_file_pkg::*;
(
  input  logic [3:0] flags_i,
  input  cond_e      cond_i,
  output logic       taken_o
);

  logic c, z, v, n;

  assign c = flags_i[FLAG_C];
  assign z = flags_i[FLAG_Z];
  assign v = flags_i[FLAG_V];
  assign n = flags_i[FLAG_N];

  // Signed comparisons use n^v as "less than", following the usual
  // subtract-and-compare flag semantics
  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_EQUAL:            taken_o = z;
      COND_NOT_EQUAL:        taken_o = ~z;
      COND_GREATER:          taken_o = ~z & (n == v);
      COND_LESS:             taken_o = n ^ v;
      COND_GREATER_OR_EQUAL: taken_o = (n == v);
      COND_LESS_OR_EQUAL:    taken_o = z | (n ^ v);
      COND_OVERFLOW:         taken_o = v;
      COND_CARRY:            taken_o = c;
      default:               taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/flag_file.sv
// flag_file
// Multi-context condition-flag file with branch evaluation and flag-hazard
// tracking. Each context holds {c, z, v, n} written by ALU writeback and a
// pending counter of flag-setters issued but not yet written back. Branches
// stall while their context has pending writes.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : flag_file_if slave modport (issue, ALU write, branch, error)
// Optional build macro FLAG_FILE_FWD_EN: a branch whose context has exactly
// one pending write, with that write arriving this cycle, is evaluated on
// the forwarded ALU flags instead of stalling.
module flag_file
  import flag_file_pkg::*;
#(
  parameter int NUM_CTX = 4,
  parameter int PEND_W  = 2
) (
  input logic     clk,
  input logic     rst,
  flag_file_if.slave bus
);

  localparam int CTX_W = ctxWidth(NUM_CTX);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic [PEND_W-1:0] pend_q  [NUM_CTX];
  logic [PEND_W-1:0] pend_d  [NUM_CTX];
  logic [3:0]        flags_q [NUM_CTX];
  logic [3:0]        flags_d [NUM_CTX];
  logic              respValid_q, respValid_d;
  logic              taken_q, taken_d;
  logic              err_q, err_d;

  logic [PEND_W-1:0] issuePend, aluPend, brPend;
  logic [3:0]        brFlags, aluFlags, evalFlags;
  logic              issueAcc, brStall, brAccept, condTaken;
  logic [2:0]        condField;

  // Pick out the state of the contexts addressed by each port
  always_comb begin
    issuePend = '0;
    aluPend   = '0;
    brPend    = '0;
    brFlags   = '0;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (bus.issue_ctx == CTX_W'(i)) issuePend = pend_q[i];
      if (bus.alu_ctx == CTX_W'(i)) aluPend = pend_q[i];
      if (bus.br_ctx == CTX_W'(i)) begin
        brPend  = pend_q[i];
        brFlags = flags_q[i];
      end
    end
  end

  always_comb begin
    aluFlags         = '0;
    aluFlags[FLAG_C] = bus.alu_c;
    aluFlags[FLAG_Z] = bus.alu_z;
    aluFlags[FLAG_V] = bus.alu_v;
    aluFlags[FLAG_N] = bus.alu_n;
  end

  // issue_ready is held low during reset so it only rises once reset lifts
  assign bus.issue_ready = ~rst & (issuePend != PEND_MAX);
  assign issueAcc        = bus.issue_valid & bus.issue_ready;

  // Stall decision; with forwarding, the last outstanding write landing this
  // cycle resolves the hazard and its flags feed the evaluator directly
  always_comb begin
    brStall   = bus.br_valid & (brPend != '0);
    evalFlags = brFlags;
`ifdef FLAG_FILE_FWD_EN
    if (bus.alu_valid && (bus.alu_ctx == bus.br_ctx) && (brPend == PEND_ONE)) begin
      brStall   = 1'b0;
      evalFlags = aluFlags;
    end
`endif
  end

  assign bus.br_stall = brStall;
  assign brAccept     = bus.br_valid & ~brStall;
  assign condField    = bus.br_instr[COND_HI:COND_LO];

  cond_eval u_cond_eval (
    .flags_i (evalFlags),
    .cond_i  (cond_e'(condField)),
    .taken_o (condTaken)
  );

  // Counter and flag updates. A matching issue and writeback cancel out; a
  // writeback with nothing pending still writes flags but cannot underflow.
  always_comb begin
    pend_d  = pend_q;
    flags_d = flags_q;
    for (int i = 0; i < NUM_CTX; i++) begin
      if (issueAcc && (bus.issue_ctx == CTX_W'(i)) &&
          !(bus.alu_valid && (bus.alu_ctx == CTX_W'(i)))) begin
        pend_d[i] = pend_q[i] + PEND_ONE;
      end else if (bus.alu_valid && (bus.alu_ctx == CTX_W'(i)) &&
                   !(issueAcc && (bus.issue_ctx == CTX_W'(i))) &&
                   (pend_q[i] != '0)) begin
        pend_d[i] = pend_q[i] - PEND_ONE;
      end
      if (bus.alu_valid && (bus.alu_ctx == CTX_W'(i))) flags_d[i] = aluFlags;
    end
  end

  // Branch response and sticky error next-state; br_taken keeps its last
  // value when no branch is accepted
  always_comb begin
    respValid_d = brAccept;
    taken_d     = brAccept ? condTaken : taken_q;
    err_d       = err_q | (bus.alu_valid & (aluPend == '0));
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CTX; i++) begin
        pend_q[i]  <= '0;
        flags_q[i] <= '0;
      end
      respValid_q <= 1'b0;
      taken_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      flags_q     <= flags_d;
      respValid_q <= respValid_d;
      taken_q     <= taken_d;
      err_q       <= err_d;
    end
  end

  assign bus.br_resp_valid = respValid_q;
  assign bus.br_taken      = taken_q;
  assign bus.flag_err      = err_q;

endmodule

// File: tb/tb_flag_file.sv
// tb_flag_file
// Directed table-driven bench for flag_file (NUM_CTX=4, PEND_W=2), plus
// hand-written sequences for reset, forwarding/stall and reset mid-stall.
// Honours FLAG_FILE_FWD_EN to pick the expected forwarding behaviour.
module tb_flag_file;
  import flag_file_pkg::*;

`ifdef FLAG_FILE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk;
  logic rst;
  int   checkCount = 0;
  int   passCount  = 0;

  flag_file_if #(.CTX_W(2)) bus ();

  flag_file #(.NUM_CTX(4), .PEND_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic [1:0] ic;
    logic       av;
    logic [1:0] ac;
    logic [3:0] af;
    logic       bv;
    logic [1:0] bc;
    logic [2:0] cond;
    logic       expReady;
    logic       expStall;
    logic       expResp;
    logic       expTaken;
    logic       expErr;
  } vec_t;

  vec_t vecs[25];

  // Compare one signal against its expected value and keep the tallies
  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
  endtask

  task automatic driveIdle();
    bus.issue_valid = 1'b0;
    bus.issue_ctx   = 2'd0;
    bus.alu_valid   = 1'b0;
    bus.alu_ctx     = 2'd0;
    {bus.alu_c, bus.alu_z, bus.alu_v, bus.alu_n} = 4'b0000;
    bus.br_valid    = 1'b0;
    bus.br_ctx      = 2'd0;
    bus.br_instr    = 16'h0000;
  endtask

  // Drive one vector just after an edge, check combinational outputs
  // mid-cycle, then registered outputs just after the next edge
  task automatic applyStimulus(input int idx, input vec_t v);
    bus.issue_valid = v.iv;
    bus.issue_ctx   = v.ic;
    bus.alu_valid   = v.av;
    bus.alu_ctx     = v.ac;
    {bus.alu_c, bus.alu_z, bus.alu_v, bus.alu_n} = v.af;
    bus.br_valid    = v.bv;
    bus.br_ctx      = v.bc;
    bus.br_instr    = {5'b0, v.cond, 8'h00};
    #3;
    checkOutput($sformatf("v%0d issue_ready", idx), bus.issue_ready, v.expReady);
    checkOutput($sformatf("v%0d br_stall", idx), bus.br_stall, v.expStall);
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d br_resp_valid", idx), bus.br_resp_valid, v.expResp);
    checkOutput($sformatf("v%0d br_taken", idx), bus.br_taken, v.expTaken);
    checkOutput($sformatf("v%0d flag_err", idx), bus.flag_err, v.expErr);
  endtask

  initial begin
    // iv ic av ac af bv bc cond | ready stall resp taken err ; flags {c,z,v,n}
    vecs[0]  = '{0,0,0,0,4'b0000,1,0,3'd0, 1,0,1,0,0}; // EQ ctx0, z=0
    vecs[1]  = '{0,0,0,0,4'b0000,1,0,3'd1, 1,0,1,1,0}; // NE ctx0
    vecs[2]  = '{1,2,0,0,4'b0000,0,0,3'd0, 1,0,0,1,0}; // issue ctx2
    vecs[3]  = '{0,0,1,2,4'b0011,0,0,3'd0, 1,0,0,1,0}; // write ctx2 n=1 v=1
    vecs[4]  = '{0,0,0,0,4'b0000,1,2,3'd3, 1,0,1,0,0}; // LT
    vecs[5]  = '{0,0,0,0,4'b0000,1,2,3'd4, 1,0,1,1,0}; // GE
    vecs[6]  = '{0,0,0,0,4'b0000,1,2,3'd2, 1,0,1,1,0}; // GT
    vecs[7]  = '{0,0,0,0,4'b0000,1,2,3'd5, 1,0,1,0,0}; // LE
    vecs[8]  = '{0,0,0,0,4'b0000,1,2,3'd6, 1,0,1,1,0}; // OV
    vecs[9]  = '{0,0,0,0,4'b0000,1,2,3'd7, 1,0,1,0,0}; // CY
    vecs[10] = '{1,1,0,0,4'b0000,0,0,3'd0, 1,0,0,0,0}; // issue ctx1 -> 1
    vecs[11] = '{1,1,0,0,4'b0000,0,0,3'd0, 1,0,0,0,0}; // -> 2
    vecs[12] = '{1,1,0,0,4'b0000,0,0,3'd0, 1,0,0,0,0}; // -> 3
    vecs[13] = '{1,1,0,0,4'b0000,1,1,3'd0, 0,1,0,0,0}; // 4th issue refused
    vecs[14] = '{0,1,1,1,4'b1100,1,1,3'd0, 0,1,0,0,0}; // write -> 2
    vecs[15] = '{0,1,1,1,4'b1100,1,1,3'd0, 1,1,0,0,0}; // ready again, -> 1
    vecs[16] = '{0,1,1,1,4'b1100,0,1,3'd0, 1,0,0,0,0}; // -> 0
    vecs[17] = '{0,0,0,0,4'b0000,1,1,3'd0, 1,0,1,1,0}; // EQ ctx1 z=1
    vecs[18] = '{1,1,0,0,4'b0000,0,0,3'd0, 1,0,0,1,0}; // issue ctx1 -> 1
    vecs[19] = '{1,1,1,1,4'b0000,0,0,3'd0, 1,0,0,1,0}; // issue+write, stays 1
    vecs[20] = '{0,1,0,0,4'b0000,1,1,3'd0, 1,1,0,1,0}; // still pending
    vecs[21] = '{0,0,1,1,4'b0000,0,0,3'd0, 1,0,0,1,0}; // write -> 0
    vecs[22] = '{0,0,0,0,4'b0000,1,1,3'd0, 1,0,1,0,0}; // EQ ctx1 z=0
    vecs[23] = '{0,0,1,0,4'b0100,0,0,3'd0, 1,0,0,0,1}; // write ctx0 w/o pending
    vecs[24] = '{0,0,0,0,4'b0000,1,0,3'd0, 1,0,1,1,1}; // flags updated, no underflow

    driveIdle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset issue_ready", bus.issue_ready, 1'b0);
    checkOutput("reset br_resp_valid", bus.br_resp_valid, 1'b0);
    checkOutput("reset br_taken", bus.br_taken, 1'b0);
    checkOutput("reset flag_err", bus.flag_err, 1'b0);
    rst = 1'b0;
    #1;
    checkOutput("post-reset issue_ready", bus.issue_ready, 1'b1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) applyStimulus(i, vecs[i]);

    // Asynchronous reset clears the sticky error and response immediately
    driveIdle();
    #2 rst = 1'b1;
    #1;
    checkOutput("async rst flag_err", bus.flag_err, 1'b0);
    checkOutput("async rst br_resp_valid", bus.br_resp_valid, 1'b0);
    checkOutput("async rst br_taken", bus.br_taken, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // One pending write on ctx3 landing with z=1 while an EQ branch waits
    bus.issue_valid = 1'b1;
    bus.issue_ctx   = 2'd3;
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b1;
    bus.alu_ctx     = 2'd3;
    {bus.alu_c, bus.alu_z, bus.alu_v, bus.alu_n} = 4'b0100;
    bus.br_valid    = 1'b1;
    bus.br_ctx      = 2'd3;
    bus.br_instr    = {5'b0, COND_EQUAL, 8'h00};
    #3;
    checkOutput("fwd br_stall", bus.br_stall, ~FWD);
    @(posedge clk);
    #1;
    bus.alu_valid = 1'b0;
    checkOutput("fwd br_resp_valid", bus.br_resp_valid, FWD);
    checkOutput("fwd br_taken", bus.br_taken, FWD);
`ifndef FLAG_FILE_FWD_EN
    #3;
    checkOutput("held br_stall", bus.br_stall, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("held br_resp_valid", bus.br_resp_valid, 1'b1);
    checkOutput("held br_taken", bus.br_taken, 1'b1);
`endif
    checkOutput("fwd flag_err", bus.flag_err, 1'b0);

    // Reset while a branch is stalled, with a response still showing
    driveIdle();
    bus.issue_valid = 1'b1;
    bus.issue_ctx   = 2'd2;
    bus.br_valid    = 1'b1;
    bus.br_ctx      = 2'd0;
    bus.br_instr    = {5'b0, COND_NOT_EQUAL, 8'h00};
    @(posedge clk);
    #1;
    checkOutput("pre-rst br_resp_valid", bus.br_resp_valid, 1'b1);
    bus.issue_valid = 1'b0;
    bus.br_ctx      = 2'd2;
    #2;
    checkOutput("pre-rst br_stall", bus.br_stall, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("mid-stall rst br_stall", bus.br_stall, 1'b0);
    checkOutput("mid-stall rst br_resp_valid", bus.br_resp_valid, 1'b0);
    @(posedge clk);
    #1;
    driveIdle();
    rst = 1'b0;
    @(posedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/flag_file.md
# flag_file

Multi-context condition-flag file with branch-condition evaluation and flag-hazard tracking. Holds one {c, z, v, n} set per hardware context, written by the ALU writeback stage. Evaluates the 3-bit condition field of a branch instruction against those flags. Stalls the branch while flag-setting instructions for that context are still in flight. Sits between decode/issue (which issues flag-setters and branches) and ALU writeback; it is the parametrised, hazard-aware successor of `flag_rf`.

## Interface
- `NUM_CTX`, 4: number of flag contexts (≥1).
- `CTX_W`, `$clog2(NUM_CTX)` (min 1): context index width.
- `PEND_W`, 2: per-context in-flight counter width; max outstanding = 2^PEND_W − 1.
- `clk  in  1`: clock; all state updates on rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `issue_valid  in  1`: a flag-setting instruction issues this cycle.
- `issue_ctx  in  CTX_W`: context of the issued flag-setter.
- `issue_ready  out  1`: combinational; low when the counter for `issue_ctx` is saturated.
- `alu_valid  in  1`: ALU writes flags this cycle.
- `alu_ctx  in  CTX_W`: context of the flag write.
- `alu_z`, `alu_v`, `alu_n`, `alu_c  in  1 each`: new flag values.
- `br_valid  in  1`: branch requests evaluation; held stable while `br_stall` is high.
- `br_ctx  in  CTX_W`: branch context.
- `br_instr  in  16`: branch instruction; condition field is `br_instr[10:8]`.
- `br_stall  out  1`: combinational; the branch cannot be evaluated this cycle.
- `br_resp_valid  out  1`: registered; an evaluation result is present.
- `br_taken  out  1`: registered; condition result, valid with `br_resp_valid`.
- `flag_err  out  1`: sticky; set when an ALU write targets a context with zero pending writes.

## Operation
- Flag state: `NUM_CTX` × {c, z, v, n}, all 0 at reset.
- On `alu_valid`, flags[`alu_ctx`] take `alu_*` at the next edge.
- Pending counter per context, reset 0:
  - +1 on an accepted issue (`issue_valid && issue_ready`).
  - −1 on `alu_valid`.
  - Both in the same cycle on the same context: counter unchanged.
  - `issue_valid` while `issue_ready` is low is ignored; the counter does not change.
- ALU write with pending == 0:
  - The flag write is still performed.
  - The counter stays 0 (no underflow).
  - `flag_err` is set and stays set until reset.
- Condition evaluation uses encodings from `cond_code.h`:
  - EQUAL: z
  - NOT_EQUAL: !z
  - GREATER: !z & (n == v)
  - LESS: n ^ v
  - GREATER_OR_EQUAL: n == v
  - LESS_OR_EQUAL: z | (n ^ v)
  - OVERFLOW: v
  - CARRY: c
- Stall (no forwarding): `br_stall = br_valid && pending[br_ctx] != 0`.
- Branch accepted when `br_valid && !br_stall`. At the next edge:
  - `br_resp_valid` = 1.
  - `br_taken` = evaluated condition.
  - Otherwise `br_resp_valid` = 0 and `br_taken` holds its previous value.
- Same-cycle branch and issue on the same context: the branch is older. It is evaluated against the current state, and the issue takes effect afterwards.
- Reset mid-operation: all flags, counters, `br_resp_valid`, `br_taken` and `flag_err` go to 0 immediately. Any in-flight ALU writes after reset raise `flag_err`.

## Timing
- Flag write to visible in registered flags: 1 cycle.
- Branch accept to `br_resp_valid`: 1 cycle. Throughput is one branch per cycle.
- Without forwarding, a branch behind the last pending write stalls through the ALU write cycle. It is accepted on the following cycle.
- `issue_ready` and `br_stall` are purely combinational from current state and inputs. There is no combinational path from `br_*` to `issue_ready`.
- Reset values of all outputs are 0. `issue_ready` is 1 once reset is deasserted.

## Configuration
- Macro: `FLAG_FILE_FWD_EN`.
- When defined, a branch whose context has pending == 1 and a same-cycle `alu_valid` on that context is not stalled. It is evaluated on the forwarded `alu_*` flags, saving one cycle.
- When undefined, the stall is as in Operation, and evaluation always uses the registered flags.

## Structure
- Shared package or header gets:
  - The condition-code constants (extend `cond_code.h` with NOT_EQUAL, LESS_OR_EQUAL, OVERFLOW, CARRY).
  - The flag-vector bit positions {c, z, v, n}.
  - The condition-field bit range [10:8].
- One sub-module, `cond_eval`: combinational, takes 4 flags and a 3-bit condition, returns taken.

## Test plan
- Reset, then EQUAL branch on ctx 0 → `br_stall`=0; next cycle `br_resp_valid`=1, `br_taken`=0 (z=0).
- ALU write ctx 2 with n=1, v=1; then LESS on ctx 2 → taken 0. GREATER_OR_EQUAL on ctx 2 → taken 1.
- Issue 3 flag-setters on ctx 1 → `issue_ready`=0 on the 4th. ALU write ctx 1 → `issue_ready`=1 again. Branch on ctx 1 stalls until pending = 0.
- Pending = 1 on ctx 3, branch held, ALU writes z=1 same cycle:
  - With `FLAG_FILE_FWD_EN`: EQUAL is accepted that cycle, `br_taken`=1.
  - Without it: `br_stall`=1 that cycle, accepted the next cycle, `br_taken`=1.
- ALU write on ctx 0 with pending 0 → `flag_err`=1, flags updated, counter stays 0. Assert `rst` → `flag_err`=0.
- Issue and ALU write on the same ctx in one cycle → counter unchanged. Assert `rst` mid-stall → `br_stall`=0 and `br_resp_valid`=0 immediately.
